// File: rtl/fwd_seq_pkg.sv
// Shared state encoding and helpers for the forwarder read sequencer.
package fwd_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

    // Width of occupancy/credit counters able to hold the value depth itself.
    function automatic int credit_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Final-beat lane enable: only the top rem lanes, or every lane for a whole word.
    function automatic logic keep_lane(input int lane, input int rem, input int bytes);
        logic en;
        if (rem == 0) begin
            en = 1'b1;
        end else begin
            en = (lane >= (bytes - rem));
        end
        return en;
    endfunction

endpackage

// File: rtl/fwd_seq_fifo.sv
// Synchronous show-ahead FIFO with occupancy count; head entry is visible on rd_data.
module fwd_seq_fifo
    import fwd_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             wr_en,
    input  logic [WIDTH-1:0]                 wr_data,
    input  logic                             rd_en,
    output logic [WIDTH-1:0]                 rd_data,
    output logic [credit_width(DEPTH)-1:0]   count,
    output logic                             empty,
    output logic                             full
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = credit_width(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_s;
    logic             pop_s;

    // A push into a full FIFO is accepted when the head leaves in the same cycle.
    assign pop_s   = rd_en && (count_r != {CNT_W{1'b0}});
    assign push_s  = wr_en && ((count_r != CNT_W'(DEPTH)) || pop_s);
    assign rd_data = mem_r[rd_ptr_r];
    assign count   = count_r;
    assign empty   = (count_r == {CNT_W{1'b0}});
    assign full    = (count_r == CNT_W'(DEPTH));

    // Storage array; contents need no reset because count_r gates visibility.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/fwd_read_sequencer.sv
// Packet read controller: issues credit-limited word reads and re-emits them as AXI-Stream.
// Optional byte enables on m_tkeep are built when FWD_SEQ_TKEEP_EN is defined.
module fwd_read_sequencer
    import fwd_seq_pkg::*;
#(
    parameter int FWD_WIDTH      = 32,
    parameter int FWD_ADDR_WIDTH = 10,
    parameter int PLEN_WIDTH     = 12,
    parameter int RD_LAT         = 4,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      pkt_rdy,
    input  logic [PLEN_WIDTH-1:0]     pkt_len,
    output logic                      pkt_done,
    output logic [FWD_ADDR_WIDTH-1:0] fwd_addr,
    output logic                      fwd_rd_en,
    input  logic [FWD_WIDTH-1:0]      fwd_rd_data,
    output logic [FWD_WIDTH-1:0]      m_tdata,
    output logic                      m_tvalid,
    input  logic                      m_tready,
    output logic                      m_tlast
`ifdef FWD_SEQ_TKEEP_EN
    ,
    output logic [FWD_WIDTH/8-1:0]    m_tkeep
`endif
);

    localparam int BYTES = FWD_WIDTH / 8;
    localparam int CNT_W = credit_width(FIFO_DEPTH);
    localparam int CMP_W = (PLEN_WIDTH > FWD_ADDR_WIDTH) ? PLEN_WIDTH : FWD_ADDR_WIDTH;
`ifdef FWD_SEQ_TKEEP_EN
    localparam int ENTRY_W = FWD_WIDTH + 1 + BYTES;
`else
    localparam int ENTRY_W = FWD_WIDTH + 1;
`endif

    seq_state_t state_r;
    seq_state_t state_nxt_s;

    logic [CMP_W-1:0]          word_cnt_r;
    logic [CMP_W-1:0]          last_idx_r;
    logic [FWD_ADDR_WIDTH-1:0] last_addr_r;
    logic                      pkt_done_r;
    logic [RD_LAT-1:0]         pipe_vld_r;
    logic [RD_LAT-1:0]         pipe_last_r;
    logic [PLEN_WIDTH:0]       len_round_s;
    logic [PLEN_WIDTH:0]       n_words_s;
    logic                      issue_s;
    logic                      credit_ok_s;
    logic                      is_last_word_s;
    logic                      last_beat_s;
    logic [CNT_W-1:0]          inflight_s;
    logic [CNT_W:0]            occupancy_s;

    logic                      fifo_wr_s;
    logic                      fifo_rd_s;
    logic [ENTRY_W-1:0]        fifo_wdata_s;
    logic [ENTRY_W-1:0]        fifo_rdata_s;
    logic [CNT_W-1:0]          fifo_count_s;
    logic                      fifo_empty_s;
    logic                      fifo_full_s;

`ifdef FWD_SEQ_TKEEP_EN
    logic [BYTES-1:0]          pipe_keep_r [RD_LAT];
    logic [BYTES-1:0]          last_keep_r;
    logic [BYTES-1:0]          last_keep_s;
    logic [BYTES-1:0]          issue_keep_s;
    int                        rem_s;

    // Final-beat keep mask derived from the byte remainder of the offered packet.
    always_comb begin
        last_keep_s = {BYTES{1'b0}};
        rem_s       = int'(pkt_len % PLEN_WIDTH'(BYTES));
        for (int i = 0; i < BYTES; i++) begin
            last_keep_s[i] = keep_lane(i, rem_s, BYTES);
        end
    end

    assign issue_keep_s = is_last_word_s ? last_keep_r : {BYTES{1'b1}};
`endif

    assign len_round_s    = {1'b0, pkt_len} + (PLEN_WIDTH + 1)'(BYTES - 1);
    assign n_words_s      = len_round_s / (PLEN_WIDTH + 1)'(BYTES);
    assign is_last_word_s = (word_cnt_r == last_idx_r);

    // Reads in flight are the population of the latency-matched valid pipe.
    always_comb begin
        inflight_s = {CNT_W{1'b0}};
        for (int i = 0; i < RD_LAT; i++) begin
            inflight_s = inflight_s + CNT_W'(pipe_vld_r[i]);
        end
    end

    assign occupancy_s = {1'b0, inflight_s} + {1'b0, fifo_count_s};
    assign credit_ok_s = (occupancy_s < (CNT_W + 1)'(FIFO_DEPTH)) && !fifo_full_s;

    // Next-state and read-issue decode.
    always_comb begin
        state_nxt_s = state_r;
        issue_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (pkt_rdy) begin
                    if (pkt_len == {PLEN_WIDTH{1'b0}}) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_ISSUE;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (credit_ok_s) begin
                    issue_s = 1'b1;
                    if (is_last_word_s) begin
                        state_nxt_s = ST_DRAIN;
                    end else begin
                        state_nxt_s = ST_ISSUE;
                    end
                end else begin
                    state_nxt_s = ST_ISSUE;
                end
            end
            ST_DRAIN: begin
                if (last_beat_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register and the registered completion pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            pkt_done_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            pkt_done_r <= (state_nxt_s == ST_DONE);
        end
    end

    // Packet bookkeeping: word counter, final index and last issued address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt_r  <= {CMP_W{1'b0}};
            last_idx_r  <= {CMP_W{1'b0}};
            last_addr_r <= {FWD_ADDR_WIDTH{1'b0}};
`ifdef FWD_SEQ_TKEEP_EN
            last_keep_r <= {BYTES{1'b0}};
`endif
        end else if ((state_r == ST_IDLE) && pkt_rdy) begin
            word_cnt_r  <= {CMP_W{1'b0}};
            last_idx_r  <= CMP_W'(n_words_s - (PLEN_WIDTH + 1)'(1));
`ifdef FWD_SEQ_TKEEP_EN
            last_keep_r <= last_keep_s;
`endif
        end else if (issue_s) begin
            word_cnt_r  <= word_cnt_r + CMP_W'(1);
            last_addr_r <= word_cnt_r[FWD_ADDR_WIDTH-1:0];
        end
    end

    // Valid pipe carrying per-read metadata across the memory latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld_r  <= {RD_LAT{1'b0}};
            pipe_last_r <= {RD_LAT{1'b0}};
`ifdef FWD_SEQ_TKEEP_EN
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_keep_r[i] <= {BYTES{1'b0}};
            end
`endif
        end else begin
            pipe_vld_r[0]  <= issue_s;
            pipe_last_r[0] <= issue_s && is_last_word_s;
`ifdef FWD_SEQ_TKEEP_EN
            pipe_keep_r[0] <= issue_keep_s;
`endif
            for (int i = RD_LAT - 1; i > 0; i--) begin
                pipe_vld_r[i]  <= pipe_vld_r[i-1];
                pipe_last_r[i] <= pipe_last_r[i-1];
`ifdef FWD_SEQ_TKEEP_EN
                pipe_keep_r[i] <= pipe_keep_r[i-1];
`endif
            end
        end
    end

    assign fifo_wr_s = pipe_vld_r[RD_LAT-1];
`ifdef FWD_SEQ_TKEEP_EN
    assign fifo_wdata_s = {fwd_rd_data, pipe_last_r[RD_LAT-1], pipe_keep_r[RD_LAT-1]};
`else
    assign fifo_wdata_s = {fwd_rd_data, pipe_last_r[RD_LAT-1]};
`endif

    fwd_seq_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (fifo_wr_s),
        .wr_data (fifo_wdata_s),
        .rd_en   (fifo_rd_s),
        .rd_data (fifo_rdata_s),
        .count   (fifo_count_s),
        .empty   (fifo_empty_s),
        .full    (fifo_full_s)
    );

    // Stream side: head entry is gated to zero whenever the FIFO is empty.
    assign m_tvalid  = !fifo_empty_s;
    assign fifo_rd_s = m_tvalid && m_tready;
    assign m_tdata   = fifo_empty_s ? {FWD_WIDTH{1'b0}} : fifo_rdata_s[ENTRY_W-1 -: FWD_WIDTH];
`ifdef FWD_SEQ_TKEEP_EN
    assign m_tlast   = !fifo_empty_s && fifo_rdata_s[BYTES];
    assign m_tkeep   = fifo_empty_s ? {BYTES{1'b0}} : fifo_rdata_s[BYTES-1:0];
`else
    assign m_tlast   = !fifo_empty_s && fifo_rdata_s[0];
`endif
    assign last_beat_s = fifo_rd_s && m_tlast;

    assign pkt_done  = pkt_done_r;
    assign fwd_rd_en = issue_s;
    assign fwd_addr  = (state_r == ST_ISSUE) ? word_cnt_r[FWD_ADDR_WIDTH-1:0] : last_addr_r;

endmodule

// File: tb/tb_fwd_read_sequencer.sv
// Directed self-checking bench for fwd_read_sequencer with a fixed-latency memory model.
module tb_fwd_read_sequencer;

    localparam int RD_LAT = 4;

    logic        clk;
    logic        rst_n;
    logic        pkt_rdy;
    logic [11:0] pkt_len;
    logic        pkt_done;
    logic [9:0]  fwd_addr;
    logic        fwd_rd_en;
    logic [31:0] fwd_rd_data;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
`ifdef FWD_SEQ_TKEEP_EN
    logic [3:0]  m_tkeep;
`endif

    int n_cmp;
    int n_bad;

    logic [15:0] pkt_tag;
    logic [9:0]  lat_addr [RD_LAT];
    logic        lat_vld  [RD_LAT];

    int          st_rd_cnt, st_beats, st_tlast_cnt, st_done_cnt, st_done_cyc;
    int          st_last_beat_idx, st_rd_at_stall;
    logic [3:0]  st_keep_last;
    logic [9:0]  st_iss_addr [$];
    int          st_iss_cyc  [$];
    logic [31:0] st_data     [$];
    int          st_beat_cyc [$];

    fwd_read_sequencer #(
        .FWD_WIDTH      (32),
        .FWD_ADDR_WIDTH (10),
        .PLEN_WIDTH     (12),
        .RD_LAT         (RD_LAT),
        .FIFO_DEPTH     (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pkt_rdy     (pkt_rdy),
        .pkt_len     (pkt_len),
        .pkt_done    (pkt_done),
        .fwd_addr    (fwd_addr),
        .fwd_rd_en   (fwd_rd_en),
        .fwd_rd_data (fwd_rd_data),
        .m_tdata     (m_tdata),
        .m_tvalid    (m_tvalid),
        .m_tready    (m_tready),
        .m_tlast     (m_tlast)
`ifdef FWD_SEQ_TKEEP_EN
        ,
        .m_tkeep     (m_tkeep)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packet memory plus adapter: word contents encode the packet tag and address.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) lat_vld[i] <= 1'b0;
        end else begin
            lat_vld[0]  <= fwd_rd_en;
            lat_addr[0] <= fwd_addr;
            for (int i = 1; i < RD_LAT; i++) begin
                lat_vld[i]  <= lat_vld[i-1];
                lat_addr[i] <= lat_addr[i-1];
            end
        end
    end
    assign fwd_rd_data = lat_vld[RD_LAT-1] ? {pkt_tag, 6'd0, lat_addr[RD_LAT-1]} : 32'hDEAD_BEEF;

    // Offers one packet (cycle 0 = IDLE sampling cycle) and records everything it sees.
    task automatic run_pkt(input int len, input int stall, input bit rnd);
        int c;
        bit done_seen;
        st_rd_cnt = 0; st_beats = 0; st_tlast_cnt = 0; st_done_cnt = 0;
        st_done_cyc = -1; st_last_beat_idx = -1; st_rd_at_stall = -1;
        st_keep_last = 4'h0;
        st_iss_addr.delete(); st_iss_cyc.delete(); st_data.delete(); st_beat_cyc.delete();
        pkt_tag = pkt_tag + 16'd1;
        @(negedge clk);
        pkt_rdy = 1'b1;
        pkt_len = 12'(len);
        c = 0;
        done_seen = 1'b0;
        while (!done_seen && c < 2000) begin
            if (c > 0) @(negedge clk);
            if (c < stall) m_tready = 1'b0;
            else if (rnd) m_tready = 1'($urandom_range(0, 1));
            else m_tready = 1'b1;
            if (c == stall) st_rd_at_stall = st_rd_cnt;
            if (fwd_rd_en) begin
                st_rd_cnt++;
                st_iss_addr.push_back(fwd_addr);
                st_iss_cyc.push_back(c);
            end
            if (m_tvalid && m_tready) begin
                st_data.push_back(m_tdata);
                st_beat_cyc.push_back(c);
                if (m_tlast) begin
                    st_tlast_cnt++;
                    st_last_beat_idx = st_beats;
`ifdef FWD_SEQ_TKEEP_EN
                    st_keep_last = m_tkeep;
`endif
                end
                st_beats++;
            end
            if (pkt_done) begin
                done_seen = 1'b1;
                st_done_cnt++;
                st_done_cyc = c;
                pkt_rdy = 1'b0;
            end
            c++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; pkt_rdy = 1'b0; pkt_len = 12'd0; m_tready = 1'b0; pkt_tag = 16'd0;
        repeat (3) @(negedge clk);
        n_cmp++; if (pkt_done !== 1'b0) begin n_bad++; $display("FAIL reset_pkt_done: got %0d want 0", pkt_done); end
        n_cmp++; if (fwd_rd_en !== 1'b0) begin n_bad++; $display("FAIL reset_rd_en: got %0d want 0", fwd_rd_en); end
        n_cmp++; if (fwd_addr !== 10'd0) begin n_bad++; $display("FAIL reset_addr: got %0d want 0", fwd_addr); end
        n_cmp++; if (m_tvalid !== 1'b0) begin n_bad++; $display("FAIL reset_tvalid: got %0d want 0", m_tvalid); end
        n_cmp++; if (m_tlast !== 1'b0) begin n_bad++; $display("FAIL reset_tlast: got %0d want 0", m_tlast); end
`ifdef FWD_SEQ_TKEEP_EN
        n_cmp++; if (m_tkeep !== 4'h0) begin n_bad++; $display("FAIL reset_tkeep: got %h want 0", m_tkeep); end
`endif
        rst_n = 1'b1;
    endtask

    task automatic test_len16();
        logic [31:0] exp;
        run_pkt(16, 0, 1'b0);
        n_cmp++; if (st_rd_cnt !== 4) begin n_bad++; $display("FAIL len16_reads: got %0d want 4", st_rd_cnt); end
        for (int i = 0; i < 4 && i < st_iss_addr.size(); i++) begin
            n_cmp++; if (st_iss_addr[i] !== 10'(i)) begin n_bad++; $display("FAIL len16_addr%0d: got %0d want %0d", i, st_iss_addr[i], i); end
            n_cmp++; if (st_iss_cyc[i] !== 1 + i) begin n_bad++; $display("FAIL len16_issue_cyc%0d: got %0d want %0d", i, st_iss_cyc[i], 1 + i); end
        end
        n_cmp++; if (st_beats !== 4) begin n_bad++; $display("FAIL len16_beats: got %0d want 4", st_beats); end
        n_cmp++; if (((st_beat_cyc.size() > 0) ? st_beat_cyc[0] : -1) !== 6) begin n_bad++; $display("FAIL len16_first_beat_cyc: got %0d want 6", (st_beat_cyc.size() > 0) ? st_beat_cyc[0] : -1); end
        n_cmp++; if (((st_beat_cyc.size() > 3) ? st_beat_cyc[3] : -1) !== 9) begin n_bad++; $display("FAIL len16_last_beat_cyc: got %0d want 9", (st_beat_cyc.size() > 3) ? st_beat_cyc[3] : -1); end
        n_cmp++; if (st_last_beat_idx !== 3) begin n_bad++; $display("FAIL len16_tlast_pos: got %0d want 3", st_last_beat_idx); end
        n_cmp++; if (st_tlast_cnt !== 1) begin n_bad++; $display("FAIL len16_tlast_cnt: got %0d want 1", st_tlast_cnt); end
        n_cmp++; if (st_done_cyc !== 10) begin n_bad++; $display("FAIL len16_done_cyc: got %0d want 10", st_done_cyc); end
`ifdef FWD_SEQ_TKEEP_EN
        n_cmp++; if (st_keep_last !== 4'b1111) begin n_bad++; $display("FAIL len16_keep: got %b want 1111", st_keep_last); end
`endif
        for (int i = 0; i < st_data.size(); i++) begin
            exp = {pkt_tag, 6'd0, 10'(i)};
            n_cmp++; if (st_data[i] !== exp) begin n_bad++; $display("FAIL len16_data%0d: got %h want %h", i, st_data[i], exp); end
        end
    endtask

    task automatic test_len13();
        logic [31:0] exp;
        run_pkt(13, 0, 1'b0);
        n_cmp++; if (st_beats !== 4) begin n_bad++; $display("FAIL len13_beats: got %0d want 4", st_beats); end
        n_cmp++; if (st_last_beat_idx !== 3) begin n_bad++; $display("FAIL len13_tlast_pos: got %0d want 3", st_last_beat_idx); end
        n_cmp++; if (st_done_cnt !== 1) begin n_bad++; $display("FAIL len13_done: got %0d want 1", st_done_cnt); end
`ifdef FWD_SEQ_TKEEP_EN
        n_cmp++; if (st_keep_last !== 4'b1000) begin n_bad++; $display("FAIL len13_keep: got %b want 1000", st_keep_last); end
`endif
        exp = {pkt_tag, 6'd0, 10'd3};
        n_cmp++; if (((st_data.size() > 3) ? st_data[3] : 32'h0) !== exp) begin n_bad++; $display("FAIL len13_last_data: got %h want %h", (st_data.size() > 3) ? st_data[3] : 32'h0, exp); end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp;
        run_pkt(64, 20, 1'b0);
        n_cmp++; if (st_rd_at_stall !== 8) begin n_bad++; $display("FAIL bp_reads_while_stalled: got %0d want 8", st_rd_at_stall); end
        n_cmp++; if (st_rd_cnt !== 16) begin n_bad++; $display("FAIL bp_reads: got %0d want 16", st_rd_cnt); end
        n_cmp++; if (st_beats !== 16) begin n_bad++; $display("FAIL bp_beats: got %0d want 16", st_beats); end
        n_cmp++; if (st_last_beat_idx !== 15) begin n_bad++; $display("FAIL bp_tlast_pos: got %0d want 15", st_last_beat_idx); end
        n_cmp++; if (st_done_cnt !== 1) begin n_bad++; $display("FAIL bp_done: got %0d want 1", st_done_cnt); end
        for (int i = 0; i < st_data.size(); i++) begin
            exp = {pkt_tag, 6'd0, 10'(i)};
            n_cmp++; if (st_data[i] !== exp) begin n_bad++; $display("FAIL bp_data%0d: got %h want %h", i, st_data[i], exp); end
        end
    endtask

    task automatic test_zero_len();
        run_pkt(0, 0, 1'b0);
        n_cmp++; if (st_rd_cnt !== 0) begin n_bad++; $display("FAIL zero_reads: got %0d want 0", st_rd_cnt); end
        n_cmp++; if (st_beats !== 0) begin n_bad++; $display("FAIL zero_beats: got %0d want 0", st_beats); end
        n_cmp++; if (st_done_cyc !== 1) begin n_bad++; $display("FAIL zero_done_cyc: got %0d want 1", st_done_cyc); end
    endtask

    task automatic test_reset_in_drain();
        int dn;
        logic [31:0] exp;
        dn = 0;
        pkt_tag = pkt_tag + 16'd1;
        @(negedge clk);
        pkt_rdy = 1'b1; pkt_len = 12'd32; m_tready = 1'b0;
        repeat (14) begin
            @(negedge clk);
            if (pkt_done) dn++;
        end
        n_cmp++; if (m_tvalid !== 1'b1) begin n_bad++; $display("FAIL drain_tvalid_before_reset: got %0d want 1", m_tvalid); end
        n_cmp++; if (fwd_addr !== 10'd7) begin n_bad++; $display("FAIL drain_addr_before_reset: got %0d want 7", fwd_addr); end
        rst_n = 1'b0; pkt_rdy = 1'b0;
        #1;
        n_cmp++; if (pkt_done !== 1'b0) begin n_bad++; $display("FAIL abort_pkt_done: got %0d want 0", pkt_done); end
        n_cmp++; if (fwd_rd_en !== 1'b0) begin n_bad++; $display("FAIL abort_rd_en: got %0d want 0", fwd_rd_en); end
        n_cmp++; if (fwd_addr !== 10'd0) begin n_bad++; $display("FAIL abort_addr: got %0d want 0", fwd_addr); end
        n_cmp++; if (m_tvalid !== 1'b0) begin n_bad++; $display("FAIL abort_tvalid: got %0d want 0", m_tvalid); end
        n_cmp++; if (m_tlast !== 1'b0) begin n_bad++; $display("FAIL abort_tlast: got %0d want 0", m_tlast); end
        n_cmp++; if (dn !== 0) begin n_bad++; $display("FAIL abort_no_done: got %0d want 0", dn); end
        @(negedge clk);
        rst_n = 1'b1;
        run_pkt(8, 0, 1'b0);
        n_cmp++; if (st_beats !== 2) begin n_bad++; $display("FAIL post_reset_beats: got %0d want 2", st_beats); end
        n_cmp++; if (st_last_beat_idx !== 1) begin n_bad++; $display("FAIL post_reset_tlast_pos: got %0d want 1", st_last_beat_idx); end
        n_cmp++; if (st_done_cnt !== 1) begin n_bad++; $display("FAIL post_reset_done: got %0d want 1", st_done_cnt); end
        for (int i = 0; i < st_data.size(); i++) begin
            exp = {pkt_tag, 6'd0, 10'(i)};
            n_cmp++; if (st_data[i] !== exp) begin n_bad++; $display("FAIL post_reset_data%0d: got %h want %h", i, st_data[i], exp); end
        end
    endtask

    task automatic test_back_to_back();
        int len;
        int n;
        logic [3:0]  exp_keep;
        logic [31:0] exp;
        for (int p = 0; p < 200; p++) begin
            len = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 48));
            n = (len + 3) / 4;
            exp_keep = ((len % 4) == 0) ? 4'hF : 4'((4'hF << (4 - (len % 4))) & 4'hF);
            run_pkt(len, 0, 1'b1);
            n_cmp++; if (st_beats !== n) begin n_bad++; $display("FAIL b2b_beats pkt%0d len%0d: got %0d want %0d", p, len, st_beats, n); end
            n_cmp++; if (st_tlast_cnt !== ((n > 0) ? 1 : 0)) begin n_bad++; $display("FAIL b2b_tlast_cnt pkt%0d: got %0d want %0d", p, st_tlast_cnt, (n > 0) ? 1 : 0); end
            n_cmp++; if (st_done_cnt !== 1) begin n_bad++; $display("FAIL b2b_done pkt%0d: got %0d want 1", p, st_done_cnt); end
            if (n > 0) begin
                n_cmp++; if (st_last_beat_idx !== n - 1) begin n_bad++; $display("FAIL b2b_tlast_pos pkt%0d: got %0d want %0d", p, st_last_beat_idx, n - 1); end
`ifdef FWD_SEQ_TKEEP_EN
                n_cmp++; if (st_keep_last !== exp_keep) begin n_bad++; $display("FAIL b2b_keep pkt%0d len%0d: got %b want %b", p, len, st_keep_last, exp_keep); end
`endif
            end
            for (int i = 0; i < st_data.size(); i++) begin
                exp = {pkt_tag, 6'd0, 10'(i)};
                n_cmp++; if (st_data[i] !== exp) begin n_bad++; $display("FAIL b2b_data pkt%0d beat%0d: got %h want %h", p, i, st_data[i], exp); end
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_len16();
        test_len13();
        test_backpressure();
        test_zero_len();
        test_reset_in_drain();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
